// File: rtl/vga_fb_source_if.sv
// Core-side port of the framebuffer source: the queued pixel write handshake,
// the clear request and the status readback.
interface vga_fb_source_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_x;
  logic [6:0] wr_y;
  logic [7:0] wr_color;
  logic       clear_req;
  logic [7:0] clear_color;
  logic       clear_busy;
  logic [7:0] drop_count;

  modport master (
    output wr_valid, wr_x, wr_y, wr_color, clear_req, clear_color,
    input  wr_ready, clear_busy, drop_count
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_color, clear_req, clear_color,
    output wr_ready, clear_busy, drop_count
  );
endinterface

// File: rtl/vga_fb_source.sv
// 160x120x8 framebuffer scaled 4x4 onto the 640x480 active area, with a small
// write FIFO and a fill engine sharing the single RAM write port.
module vga_fb_source #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int ACTIVE_W    = 640,
  parameter int ACTIVE_H    = 480,
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_BITS   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           pixel_count,
  input  logic [9:0]           line_count,
  output logic [7:0]           color_out,
  vga_fb_source_if.slave       core
);

  localparam int FB_SIZE  = FB_W * FB_H;
  localparam int PTR_BITS = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                 state_reg, state_next;
  logic [ADDR_BITS-1:0]   clr_addr_reg, clr_addr_next;
  logic [7:0]             clr_color_reg, clr_color_next;

  logic [7:0]             fifo_x [FIFO_DEPTH];
  logic [6:0]             fifo_y [FIFO_DEPTH];
  logic [7:0]             fifo_c [FIFO_DEPTH];
  logic [PTR_BITS-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [PTR_BITS:0]      count_reg;
  logic                   full, empty, push, pop;

  logic [7:0]             head_x, head_c;
  logic [6:0]             head_y;
  logic                   head_in_range;
  logic [ADDR_BITS-1:0]   head_addr, head_y_w;
  logic [7:0]             drop_reg;

  logic [7:0]             fb_ram [FB_SIZE];
  logic                   ram_we;
  logic [ADDR_BITS-1:0]   ram_waddr;
  logic [7:0]             ram_wdata;

  logic [ADDR_BITS-1:0]   rd_sx, rd_sy, rd_addr, rd_addr_reg;
  logic                   in_active, active_reg, active_d_reg;
  logic [7:0]             ram_q_reg;

  // ---------------- write FIFO ----------------
  assign full  = (count_reg == (PTR_BITS+1)'(FIFO_DEPTH));
  assign empty = (count_reg == '0);
  assign push  = core.wr_valid && !full;
  // A clear request wins over the drain in the cycle it is accepted.
  assign pop   = (state_reg == IDLE) && !empty && !core.clear_req;

  assign core.wr_ready = !full;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_BITS'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_BITS'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_BITS+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_BITS+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_x[wr_ptr_reg] <= core.wr_x;
      fifo_y[wr_ptr_reg] <= core.wr_y;
      fifo_c[wr_ptr_reg] <= core.wr_color;
    end
  end

  assign head_x        = fifo_x[rd_ptr_reg];
  assign head_y        = fifo_y[rd_ptr_reg];
  assign head_c        = fifo_c[rd_ptr_reg];
  assign head_in_range = (head_x < 8'(FB_W)) && (head_y < 7'(FB_H));
  assign head_y_w      = ADDR_BITS'(head_y);
  assign head_addr     = (head_y_w << 7) + (head_y_w << 5) + ADDR_BITS'(head_x);

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_reg <= '0;
    end else if (pop && !head_in_range && drop_reg != 8'hFF) begin
      drop_reg <= drop_reg + 8'd1;
    end
  end

  assign core.drop_count = drop_reg;

  // ---------------- clear engine ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      clr_addr_reg  <= '0;
      clr_color_reg <= '0;
    end else begin
      state_reg     <= state_next;
      clr_addr_reg  <= clr_addr_next;
      clr_color_reg <= clr_color_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    clr_addr_next  = clr_addr_reg;
    clr_color_next = clr_color_reg;
    case (state_reg)
      IDLE: begin
        if (core.clear_req) begin
          state_next     = CLEAR;
          clr_addr_next  = '0;
          clr_color_next = core.clear_color;
        end
      end
      CLEAR: begin
        if (clr_addr_reg == ADDR_BITS'(FB_SIZE - 1)) begin
          state_next    = IDLE;
          clr_addr_next = '0;
        end else begin
          clr_addr_next = clr_addr_reg + ADDR_BITS'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign core.clear_busy = (state_reg == CLEAR);

  // ---------------- shared RAM write port ----------------
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_addr_reg;
    ram_wdata = clr_color_reg;
    if (state_reg == CLEAR) begin
      ram_we = 1'b1;
    end else if (pop && head_in_range) begin
      ram_we    = 1'b1;
      ram_waddr = head_addr;
      ram_wdata = head_c;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) fb_ram[ram_waddr] <= ram_wdata;
    ram_q_reg <= fb_ram[rd_addr_reg];
  end

  // ---------------- display read path ----------------
  assign rd_sx     = ADDR_BITS'(pixel_count >> SCALE_SHIFT);
  assign rd_sy     = ADDR_BITS'(line_count >> SCALE_SHIFT);
  assign rd_addr   = (rd_sy << 7) + (rd_sy << 5) + rd_sx;
  assign in_active = (pixel_count < 10'(ACTIVE_W)) && (line_count < 10'(ACTIVE_H));

  always_ff @(posedge clk) begin
    rd_addr_reg <= rd_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_reg   <= 1'b0;
      active_d_reg <= 1'b0;
    end else begin
      active_reg   <= in_active;
      active_d_reg <= active_reg;
    end
  end

  // Blanking is masked here so whatever the RAM returns off-screen never escapes.
  assign color_out = active_d_reg ? ram_q_reg : 8'd0;

endmodule
